// File: rtl/uart_rx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_framer: oversampling 8N1 receiver, bytes zero-extended to 32 bits. |
// | Optional even parity: define UART_RX_PARITY_EN.     Revision: 1.0          |
// +----------------------------------------------------------------------------+
module uart_rx_framer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_WIDTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        framing_error,
   output logic        parity_error,
   output logic        busy
);

   localparam logic [CNT_WIDTH-1:0] c_HALF_M1 = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_WIDTH-1:0] c_BIT_M1  = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           shift_q, shift_d;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;
   logic                 bit_end;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 pbad_q, pbad_d;
`endif

   assign rx_s    = sync2_q;
   assign bit_end = (cnt_q == c_BIT_M1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
         pbad_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync1_q <= rx;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
         pbad_q  <= pbad_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
      pbad_d  = pbad_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
               pbad_d  = 1'b0;
`endif
            end
         end
         S_START: begin
            // Mid-start-bit check rejects short low glitches.
            if (cnt_q == c_HALF_M1) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
               if ((^shift_q) ^ rx_s) begin
                  perr_d = 1'b1;
                  pbad_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end
`endif
         S_STOP: begin
            // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
            if (bit_end) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (!pbad_q) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = shift_q;
                  valid_d = 1'b1;
`endif
               end else begin
                  state_d = S_WAIT_HIGH;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data_out      = {24'b0, data_q};
   assign data_valid    = valid_q;
   assign framing_error = ferr_q;
   assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_error  = perr_q;
`else
   assign parity_error  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
`default_nettype none
// Directed bench for uart_rx_framer at CLKS_PER_BIT=16; expected values hand-computed.
module tb_uart_rx_framer;
   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [31:0] data_out;
   logic        data_valid, framing_error, parity_error, busy;

   int n_vec = 0;
   int n_err = 0;

   int cyc = 0, nvalid = 0, nferr = 0, nperr = 0, both = 0, wide = 0;
   int busy_rise = 0, v_last = 0, v_prev = 0;
   logic pv = 1'b0, pb = 1'b0;
   logic [31:0] dq[$];

   uart_rx_framer #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
      .data_valid(data_valid), .framing_error(framing_error),
      .parity_error(parity_error), .busy(busy));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (busy && !pb) busy_rise = cyc;
      pb = busy;
      if (data_valid) begin
         nvalid = nvalid + 1;
         v_prev = v_last;
         v_last = cyc;
         dq.push_back(data_out);
      end
      if (data_valid && pv) wide = wide + 1;
      pv = data_valid;
      if (framing_error) nferr = nferr + 1;
      if (parity_error) nperr = nperr + 1;
      if (data_valid && framing_error) both = both + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      wait_cyc(n);
   endtask

   task automatic send_data(input logic [7:0] b);
      rx = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(CPB);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_p(input logic [7:0] b, input logic par, input logic stop);
      send_data(b);
      rx = par;
      wait_cyc(CPB);
      rx = stop;
      wait_cyc(CPB);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_frame_p(b, ^b, stop);
   endtask
`else
   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_data(b);
      rx = stop;
      wait_cyc(CPB);
   endtask
`endif

   initial begin
      int base;
      int pbase;
      logic [7:0] ab;
      reset = 1'b1;
      rx    = 1'b1;
      wait_cyc(3);
      check("rst_data_out", data_out, 32'h0);
      check("rst_data_valid", {31'b0, data_valid}, 32'h0);
      check("rst_framing_error", {31'b0, framing_error}, 32'h0);
      check("rst_parity_error", {31'b0, parity_error}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      reset = 1'b0;
      idle(20);

      // 1: clean frame
      send_frame(8'h55, 1'b1);
      idle(20);
      check("t1_nvalid", nvalid, 1);
      check("t1_data_out", data_out, 32'h55);
      check("t1_latency", v_last - busy_rise, CPB / 2 + (FRAME - 1) * CPB);
      check("t1_busy", {31'b0, busy}, 32'h0);
      check("t1_nferr", nferr, 0);

      // 2: short low glitch
      rx = 1'b0;
      wait_cyc(4);
      rx = 1'b1;
      wait_cyc(2);
      check("t2_busy_high", {31'b0, busy}, 32'h1);
      idle(30);
      check("t2_busy_low", {31'b0, busy}, 32'h0);
      check("t2_nvalid", nvalid, 1);
      check("t2_nferr", nferr, 0);

      // 3: bad stop bit followed by a held-low line
      send_frame(8'hA3, 1'b0);
      rx = 1'b0;
      wait_cyc(40);
      check("t3_nferr", nferr, 1);
      check("t3_data_out", data_out, 32'h55);
      check("t3_busy_held", {31'b0, busy}, 32'h1);
      check("t3_nvalid", nvalid, 1);
      idle(10);
      check("t3_busy_release", {31'b0, busy}, 32'h0);

      // 4: back-to-back frames
      base = nvalid;
      send_frame(8'h01, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check("t4_nvalid", nvalid, base + 2);
      check("t4_spacing", v_last - v_prev, FRAME * CPB);
      check("t4_first_data", dq[dq.size() - 2], 32'h01);
      check("t4_second_data", data_out, 32'hFF);

      // 5: reset in the middle of data bit 3
      base = nvalid;
      ab = 8'h96;
      rx = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = ab[i];
         wait_cyc(CPB);
      end
      rx = ab[3];
      wait_cyc(8);
      reset = 1'b1;
      wait_cyc(2);
      check("t5_rst_data_out", data_out, 32'h0);
      check("t5_rst_busy", {31'b0, busy}, 32'h0);
      reset = 1'b0;
      wait_cyc(6);
      idle(60);
      check("t5_aborted_nvalid", nvalid, base);
      send_frame(8'h3C, 1'b1);
      idle(20);
      check("t5_nvalid", nvalid, base + 1);
      check("t5_data_out", data_out, 32'h3C);

`ifdef UART_RX_PARITY_EN
      // 6: parity mismatch, then the same byte with correct parity
      base  = nvalid;
      pbase = nperr;
      send_frame_p(8'h07, 1'b0, 1'b1);
      idle(20);
      check("t6_perr", nperr, pbase + 1);
      check("t6_no_valid", nvalid, base);
      check("t6_data_kept", data_out, 32'h3C);
      send_frame_p(8'h07, 1'b1, 1'b1);
      idle(20);
      check("t6_nvalid", nvalid, base + 1);
      check("t6_data_out", data_out, 32'h07);
      check("t6_perr_stable", nperr, pbase + 1);
`else
      pbase = nperr;
      check("parity_tied_low", pbase, 0);
`endif

      check("valid_ferr_overlap", both, 0);
      check("valid_pulse_width", wide, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Receive-side serial front end for the CPU UART path.
- Oversamples the asynchronous `rx` pin, deframes 8N1 characters (LSB first) and delivers each byte zero-extended to 32 bits, with a one-cycle strobe.
- Sits directly upstream of the receive FIFO: `data_out` drives the FIFO `data_in`; `data_valid` drives the FIFO `write`.
- The datapath reads the received word through the FIFO output into the register-file write mux.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud); legal range 4..65535.
- CNT_WIDTH, 16, bit-counter width; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- data_out  output  32  {24'b0, received byte}; holds its value until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out is updated with a good frame.
- framing_error  output  1  one-cycle pulse when the stop-bit sample reads 0.
- parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 when the parity feature is compiled out.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (async, on assert):
  - state = IDLE.
  - Both synchronizer flops = 1.
  - data_out = 0; data_valid, framing_error, parity_error, busy = 0.
  - Bit counter, bit index and shift register = 0.
- Synchronizer: `rx` passes through two flops to give rx_s. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2, using integer division.
- States: IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
- IDLE:
  - rx_s == 0 → START, counter cleared.
  - Otherwise stay.
- START:
  - Counter increments each cycle.
  - The start-bit sample is taken on the cycle the counter reaches HALF-1.
  - If rx_s == 1 at the sample, the start is a glitch → IDLE, with no pulse.
  - If rx_s == 0 → DATA, counter cleared, bit index = 0.
- DATA:
  - Each data bit is sampled when the counter reaches CLKS_PER_BIT-1; the counter then clears.
  - Sampled bits shift in LSB first.
  - After the sample at bit index 7 → STOP, or → PARITY when the parity feature is compiled in.
- STOP: sampled when the counter reaches CLKS_PER_BIT-1.
  - rx_s == 1:
    - data_out <= {24'b0, shift}.
    - data_valid = 1 for exactly one cycle.
    - → IDLE.
  - rx_s == 0:
    - framing_error = 1 for one cycle.
    - data_out is unchanged and there is no data_valid.
    - → WAIT_HIGH.
- WAIT_HIGH: stays until rx_s == 1, then → IDLE. This absorbs breaks and stuck-low lines.
- Latency: the data_valid edge is HALF + 9*CLKS_PER_BIT cycles after START is entered (HALF + 10*CLKS_PER_BIT with parity).
- START is entered 2 cycles after the rx falling edge, due to the synchronizer.
- Back-to-back frames: the transition back to IDLE occurs mid-stop-bit, so a start edge arriving immediately after the stop bit is caught with no lost character.
- data_valid and framing_error are never high in the same cycle.
- Reset mid-frame:
  - The frame is abandoned and no pulse is generated.
  - After release, the block re-arms on the next falling edge of rx_s. A partially seen frame may be treated as a glitch or as a framing error.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit at CLKS_PER_BIT-1.
  - Mismatch (XOR of data and parity bit = 1): parity_error pulses for one cycle.
  - The frame still proceeds to STOP, but its data_valid and its data_out update are suppressed.
  - If the stop bit is also bad, framing_error pulses as well, in the STOP cycle.
- Undefined: no PARITY state; parity_error is tied to 0; the frame is 8N1.

Test Plan (CLKS_PER_BIT=16):
1. Send 0x55 as 8N1 from idle → one data_valid pulse 152 cycles after START entry; data_out = 0x00000055; busy returns to 0.
2. Hold rx low for 4 cycles, then high → no data_valid and no framing_error; busy pulses high, then returns to IDLE.
3. Send 0xA3 with stop bit 0, then hold rx low for 40 cycles → one framing_error pulse; data_out keeps its previous value 0x55; busy stays 1 until rx returns high.
4. Send 0x01 followed immediately by 0xFF, with no idle gap → two data_valid pulses exactly 160 cycles apart; data_out = 0x01, then 0xFF.
5. Assert reset during data bit 3 of 0x96, then send 0x3C → no pulse for the aborted frame; one data_valid with data_out = 0x0000003C.
6. With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 → parity_error pulse and no data_valid. Resend with parity bit 1 → data_valid, data_out = 0x00000007.
